// File: rtl/scalar_dmem_if.sv
// scalar_dmem_if: scalar LS unit to data-memory request/response bundle.
// dmem_err is present only when SCALAR_DMEM_MISALIGN_ERR_EN is defined.
interface scalar_dmem_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        busy;
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
  logic        dmem_err;
`endif
  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload, busy
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
    , input dmem_err
`endif
  );
  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload, busy
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
    , output dmem_err
`endif
  );
endinterface

// File: rtl/scalar_dmem_responder.sv
// scalar_dmem_responder: word SRAM model answering one request at a time with a fixed-latency dhit pulse.
// Optional SCALAR_DMEM_MISALIGN_ERR_EN: misaligned requests skip the access and raise dmem_err in HIT.
module scalar_dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic          CLK,
  input logic          nRST,
  scalar_dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, HIT, TURN} state_t;
  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_q, c_idx;
  logic [31:0]     data_q, c_data;
  logic            wr_q, c_wr, c_mis, go_hit;
  logic [31:0]     mem [DEPTH];
  logic            unused;
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
  logic            mis_q;
`endif
  assign unused = ^{bus.dmemaddr[31:AW+2], bus.dmemaddr[1:0]};
  // In IDLE with LATENCY=1 the commit happens on the accepting edge, so use the live inputs there.
  always_comb begin
    c_idx  = (state == IDLE) ? bus.dmemaddr[AW+1:2] : idx_q;
    c_data = (state == IDLE) ? bus.dmemstore : data_q;
    c_wr   = (state == IDLE) ? bus.dmemWEN : wr_q;
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
    c_mis  = (state == IDLE) ? |bus.dmemaddr[1:0] : mis_q;
`else
    c_mis  = 1'b0;
`endif
    go_hit = (state == IDLE) ? ((bus.dmemREN || bus.dmemWEN) && LATENCY == 1)
                             : (state == WAIT && cnt == '0);
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      cnt          <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      bus.dhit     <= 1'b0;
      bus.dmemload <= '0;
      bus.busy     <= 1'b0;
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
      mis_q        <= 1'b0;
      bus.dmem_err <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (go_hit) begin
        state        <= HIT;
        bus.dhit     <= 1'b1;
        bus.dmemload <= (c_wr || c_mis) ? '0 : mem[c_idx];
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
        bus.dmem_err <= c_mis;
`endif
        if (c_wr && !c_mis) mem[c_idx] <= c_data;
      end
      case (state)
        IDLE: if (bus.dmemREN || bus.dmemWEN) begin
          idx_q    <= bus.dmemaddr[AW+1:2];
          data_q   <= bus.dmemstore;
          wr_q     <= bus.dmemWEN;
          bus.busy <= 1'b1;
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
          mis_q    <= |bus.dmemaddr[1:0];
`endif
          if (LATENCY != 1) begin
            state <= WAIT;
            cnt   <= 4'(LATENCY > 1 ? LATENCY - 2 : 0);
          end
        end
        WAIT: if (cnt != '0) cnt <= cnt - 4'd1;
        HIT: begin
          state        <= TURN;
          bus.dhit     <= 1'b0;
          bus.dmemload <= '0;
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
          bus.dmem_err <= 1'b0;
`endif
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_scalar_dmem_responder.sv
// tb_scalar_dmem_responder: three responders (LATENCY 2, 1, 4) driven by directed and random
// transactions, checked against an array memory model and the request-to-dhit latency rule.
module tb_scalar_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LATS [3] = '{2, 1, 4};
  logic        clk = 1'b0;
  logic [2:0]  nrst, ren, wen, hit, bsy;
  logic [31:0] addr [3];
  logic [31:0] store [3];
  logic [31:0] load [3];
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
  logic [2:0]  err;
`endif
  logic [31:0] m [3][DEPTH];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    scalar_dmem_if b ();
    assign b.dmemREN   = ren[g];
    assign b.dmemWEN   = wen[g];
    assign b.dmemaddr  = addr[g];
    assign b.dmemstore = store[g];
    assign hit[g]      = b.dhit;
    assign load[g]     = b.dmemload;
    assign bsy[g]      = b.busy;
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
    assign err[g]      = b.dmem_err;
`endif
    scalar_dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATS[g])) dut (
      .CLK(clk), .nRST(nrst[g]), .bus(b.slave));
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic clear_model(input int k);
    for (int i = 0; i < DEPTH; i++) m[k][i] = '0;
  endtask
  // One complete transaction: request, wait for dhit, drop, then TURN and IDLE.
  task automatic xact(input int k, input bit w, input bit r, input logic [31:0] a,
                      input logic [31:0] d, input bit drop);
    int idx, seen;
    bit mis;
    logic [31:0] exp_load;
    idx = int'((a >> 2) % DEPTH);
    mis = 1'b0;
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
    mis = (a[1:0] != 2'b00);
`endif
    exp_load = (w || mis) ? '0 : m[k][idx];
    if (w && !mis) m[k][idx] = d;
    chk("idle_busy", {31'b0, bsy[k]}, 0);
    ren[k] = r; wen[k] = w; addr[k] = a; store[k] = d;
    seen = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1 && drop) begin
        ren[k] = 1'b0; wen[k] = 1'b0; addr[k] = $urandom; store[k] = $urandom;
      end
      if (hit[k]) begin
        seen = c;
        break;
      end
      chk("wait_load", load[k], 0);
      chk("wait_busy", {31'b0, bsy[k]}, 1);
    end
    chk("latency", seen, LATS[k]);
    chk("hit_load", load[k], exp_load);
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
    chk("hit_err", {31'b0, err[k]}, {31'b0, mis});
`endif
    ren[k] = 1'b0; wen[k] = 1'b0;
    @(negedge clk);
    chk("turn_hit", {31'b0, hit[k]}, 0);
    chk("turn_load", load[k], 0);
    chk("turn_busy", {31'b0, bsy[k]}, 1);
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
    chk("turn_err", {31'b0, err[k]}, 0);
`endif
    @(negedge clk);
    chk("idle_hit", {31'b0, hit[k]}, 0);
  endtask
  initial begin
    int pulses, first;
    logic [31:0] exp_held;
    nrst = '0; ren = '0; wen = '0;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; store[k] = '0; clear_model(k);
    end
    repeat (2) @(negedge clk);
    nrst = '1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_hit", {31'b0, hit[k]}, 0);
      chk("rst_busy", {31'b0, bsy[k]}, 0);
      chk("rst_load", load[k], 0);
    end
    xact(0, 0, 1, 32'h10, 0, 0);
    xact(0, 1, 0, 32'h40, 32'hDEADBEEF, 0);
    xact(0, 0, 1, 32'h40, 0, 0);
    // Request held across dhit: exactly one new transaction, starting the cycle after TURN.
    exp_held = m[0][16];
    ren[0] = 1'b1; addr[0] = 32'h40;
    for (int c = 0; c < 40 && !hit[0]; c++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("held_first_hit", {31'b0, hit[0]}, 1);
    pulses = 0; first = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); @(negedge clk);
      if (hit[0]) begin
        pulses++;
        if (first == 0) begin
          first = c;
          chk("held_load", load[0], exp_held);
        end
      end
      if (c == 5) ren[0] = 1'b0;
    end
    chk("held_pulses", pulses, 1);
    chk("held_pos", first, 2 + LATS[0]);
    chk("held_idle", {31'b0, bsy[0]}, 0);
    xact(0, 1, 0, 32'h400, 32'h12345678, 0);
    xact(0, 0, 1, 32'h000, 0, 0);
    xact(0, 1, 1, 32'h8, 32'hA5A5A5A5, 0);
    xact(0, 0, 1, 32'h8, 0, 0);
    xact(1, 0, 1, 32'h40, 0, 0);
    xact(1, 1, 0, 32'h44, 32'hCAFEF00D, 1);
    xact(1, 0, 1, 32'h44, 0, 0);
    // Reset during WAIT on the LATENCY=4 instance: store must not land.
    ren[2] = 1'b0; wen[2] = 1'b1; addr[2] = 32'h20; store[2] = 32'h55;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    chk("midrst_busy_pre", {31'b0, bsy[2]}, 1);
    nrst[2] = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, bsy[2]}, 0);
    chk("midrst_hit", {31'b0, hit[2]}, 0);
    clear_model(2);
    wen[2] = 1'b0;
    repeat (2) @(negedge clk);
    nrst[2] = 1'b1;
    @(negedge clk);
    xact(2, 0, 1, 32'h20, 0, 0);
`ifdef SCALAR_DMEM_MISALIGN_ERR_EN
    xact(0, 1, 0, 32'h22, 32'hFFFFFFFF, 0);
    xact(0, 0, 1, 32'h20, 0, 0);
`endif
    for (int n = 0; n < 120; n++) begin
      int k, kind;
      logic [31:0] a;
      k = n % 3;
      kind = $urandom_range(0, 2);
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      xact(k, kind != 0, kind != 1, a, $urandom, $urandom_range(0, 3) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
